// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter/sequencer for a shared SRAM: one access at a time, registered strobes and acks.
// Tie-break policy: define SRAM_ARB_RR_EN for round-robin, otherwise requester A has fixed priority.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4,
  parameter int TIMEOUT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_ack,
  output logic                  a_err,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  b_ack,
  output logic                  b_err,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_done,
  input  logic                  mem_wr_done,
  output logic                  busy,
  output logic [1:0]            dbg_state_o,
  output logic                  dbg_last_b_o
);

  // Handshake: a requester holds req (with we/addr/wdata stable) until its one-cycle
  // ack; it may drop req or present a new request on the edge that ends the ack cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t                state_q;
  logic                  win_b_q;
  logic                  last_b_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CW-1:0]         cnt_q;
  logic                  busy_q;
  logic                  mem_read_q, mem_write_q;
  logic                  a_ack_q, a_err_q, b_ack_q, b_err_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic                  grant_b_d;
  logic                  sel_we_d;
  logic                  done_match_d;

  always_comb begin
    grant_b_d = 1'b0;
    if (a_req && b_req) begin
`ifdef SRAM_ARB_RR_EN
      grant_b_d = ~last_b_q;
`else
      grant_b_d = 1'b0;
`endif
    end else if (b_req) begin
      grant_b_d = 1'b1;
    end
  end

  assign sel_we_d     = grant_b_d ? b_we : a_we;
  assign done_match_d = we_q ? mem_wr_done : mem_rd_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      win_b_q     <= 1'b0;
      last_b_q    <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      a_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      // Strobes, acks and errs are single-cycle pulses unless re-asserted below.
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      a_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      b_err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (a_req || b_req) begin
            win_b_q     <= grant_b_d;
            we_q        <= sel_we_d;
            addr_q      <= grant_b_d ? b_addr : a_addr;
            wdata_q     <= grant_b_d ? b_wdata : a_wdata;
            mem_write_q <= sel_we_d;
            mem_read_q  <= ~sel_we_d;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (done_match_d) begin
            if (!we_q && win_b_q)  b_rdata_q <= mem_rd_data;
            if (!we_q && !win_b_q) a_rdata_q <= mem_rd_data;
            a_ack_q <= ~win_b_q;
            b_ack_q <= win_b_q;
            state_q <= DONE;
          end else if (cnt_q == CW'(TIMEOUT)) begin
            a_ack_q <= ~win_b_q;
            b_ack_q <= win_b_q;
            a_err_q <= ~win_b_q;
            b_err_q <= win_b_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          last_b_q <= win_b_q;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a_ack          = a_ack_q;
  assign a_err          = a_err_q;
  assign a_rdata        = a_rdata_q;
  assign b_ack          = b_ack_q;
  assign b_err          = b_err_q;
  assign b_rdata        = b_rdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_read_addr  = addr_q;
  assign mem_write_addr = addr_q;
  assign mem_wr_data    = wdata_q;
  assign busy           = busy_q;
  assign dbg_state_o    = state_q;
  assign dbg_last_b_o   = last_b_q;

endmodule
